fu_alu_arbiter: RTL and testbench

- Shares one combinational tensor-core ALU between NREQ requesters, e.g. lane controllers and the address-generation unit.
- Round-robin arbiter on a valid/ready request side; drives the shared ALU's aluop, port_a, port_b and enable inputs.
- Captures the ALU result and flags into a single-entry response register with valid/ready and a requester ID.
- Full throughput: one operation per cycle when the response side does not stall.

---
 rtl/fu_alu_arbiter.sv | 113 +++++++++++
 tb/tb_fu_alu_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fu_alu_arbiter.sv
// Round-robin sharing of one combinational ALU among NREQ requesters; 1-cycle accept-to-response latency.
// A stalled response register (resp_valid & !resp_ready) blocks all grants and freezes the pointer.
module fu_alu_arbiter #(
  parameter int NREQ    = 4,
  parameter int ALUOP_W = 4,
  parameter int WORD_W  = 32,
  parameter int ID_W    = 2
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*ALUOP_W-1:0] req_aluop,
  input  logic [NREQ*WORD_W-1:0]  req_port_a,
  input  logic [NREQ*WORD_W-1:0]  req_port_b,
  output logic [ALUOP_W-1:0]      alu_aluop,
  output logic [WORD_W-1:0]       alu_port_a,
  output logic [WORD_W-1:0]       alu_port_b,
  output logic                    alu_enable,
  input  logic [WORD_W-1:0]       alu_port_output,
  input  logic                    alu_negative,
  input  logic                    alu_overflow,
  input  logic                    alu_zero,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [ID_W-1:0]         resp_id,
  output logic [WORD_W-1:0]       resp_result,
  output logic                    resp_negative,
  output logic                    resp_overflow,
  output logic                    resp_zero
);

  logic [ID_W-1:0]   r_rr_ptr;
  logic              r_resp_valid;
  logic [ID_W-1:0]   r_resp_id;
  logic [WORD_W-1:0] r_resp_result;
  logic              r_resp_negative;
  logic              r_resp_overflow;
  logic              r_resp_zero;

  logic              w_can_issue;
  logic              w_gnt_vld;
  logic [ID_W-1:0]   w_gnt_idx;
  logic [ID_W-1:0]   w_next_ptr;
  int                w_idx;

  // Reset gates issue so nothing is granted on a reset edge.
  assign w_can_issue = nRST && (!r_resp_valid || resp_ready);

  // Scan from the farthest offset down so the entry nearest rr_ptr wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_idx     = 0;
    if (w_can_issue) begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        w_idx = (int'(r_rr_ptr) + k) % NREQ;
        if (req_valid[ID_W'(w_idx)]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = ID_W'(w_idx);
        end
      end
    end
  end

  always_comb begin
    req_ready  = '0;
    alu_aluop  = '0;
    alu_port_a = '0;
    alu_port_b = '0;
    alu_enable = w_gnt_vld;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt_vld && (w_gnt_idx == ID_W'(i))) begin
        req_ready[i] = 1'b1;
        alu_aluop    = req_aluop[i*ALUOP_W +: ALUOP_W];
        alu_port_a   = req_port_a[i*WORD_W +: WORD_W];
        alu_port_b   = req_port_b[i*WORD_W +: WORD_W];
      end
    end
  end

  assign w_next_ptr = (w_gnt_idx == ID_W'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_rr_ptr        <= '0;
      r_resp_valid    <= 1'b0;
      r_resp_id       <= '0;
      r_resp_result   <= '0;
      r_resp_negative <= 1'b0;
      r_resp_overflow <= 1'b0;
      r_resp_zero     <= 1'b0;
    end else if (w_gnt_vld) begin
      r_rr_ptr        <= w_next_ptr;
      r_resp_valid    <= 1'b1;
      r_resp_id       <= w_gnt_idx;
      r_resp_result   <= alu_port_output;
      r_resp_negative <= alu_negative;
      r_resp_overflow <= alu_overflow;
      r_resp_zero     <= alu_zero;
    end else if (resp_ready) begin
      r_resp_valid    <= 1'b0;
    end
  end

  assign resp_valid    = r_resp_valid;
  assign resp_id       = r_resp_id;
  assign resp_result   = r_resp_result;
  assign resp_negative = r_resp_negative;
  assign resp_overflow = r_resp_overflow;
  assign resp_zero     = r_resp_zero;

endmodule

// File: tb/tb_fu_alu_arbiter.sv
// Bench for fu_alu_arbiter: stub ALU, queue-free reference model of grant order and
// response register, per-cycle compare at negedge, plus literal expectations.
module tb_fu_alu_arbiter;
  localparam int NREQ = 4;
  localparam int AW   = 4;
  localparam int WW   = 32;
  localparam int IW   = 2;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;

  logic                 CLK = 1'b0;
  logic                 nRST;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_aluop;
  logic [NREQ*WW-1:0]   req_port_a;
  logic [NREQ*WW-1:0]   req_port_b;
  logic [AW-1:0]        alu_aluop;
  logic [WW-1:0]        alu_port_a;
  logic [WW-1:0]        alu_port_b;
  logic                 alu_enable;
  logic [WW-1:0]        alu_port_output;
  logic                 alu_negative;
  logic                 alu_overflow;
  logic                 alu_zero;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [IW-1:0]        resp_id;
  logic [WW-1:0]        resp_result;
  logic                 resp_negative;
  logic                 resp_overflow;
  logic                 resp_zero;

  int checks   = 0;
  int failures = 0;

  fu_alu_arbiter #(.NREQ(NREQ), .ALUOP_W(AW), .WORD_W(WW), .ID_W(IW)) dut (
    .CLK(CLK), .nRST(nRST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_aluop(req_aluop), .req_port_a(req_port_a), .req_port_b(req_port_b),
    .alu_aluop(alu_aluop), .alu_port_a(alu_port_a), .alu_port_b(alu_port_b),
    .alu_enable(alu_enable), .alu_port_output(alu_port_output),
    .alu_negative(alu_negative), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_negative(resp_negative),
    .resp_overflow(resp_overflow), .resp_zero(resp_zero)
  );

  always #5 CLK = ~CLK;

  // Returns {negative, overflow, zero, result}.
  function automatic logic [34:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        v;
    v = 1'b0;
    case (op)
      OP_ADD:  begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      OP_SUB:  begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      OP_AND:  r = a & b;
      default: r = a | b;
    endcase
    return {r[31], v, (r == 32'd0), r};
  endfunction

  always_comb begin
    {alu_negative, alu_overflow, alu_zero, alu_port_output} = alu_fn(alu_aluop, alu_port_a, alu_port_b);
  end

  // Reference model: pointer as an integer, response register as plain fields.
  bit          m_started = 0;
  int          m_ptr = 0;
  bit          m_rv = 0;
  int          m_id = 0;
  logic [34:0] m_flags_res = '0;

  function automatic int model_grant();
    if (nRST !== 1'b1) return -1;
    if (m_rv && !resp_ready) return -1;
    for (int k = 0; k < NREQ; k++)
      if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  always @(posedge CLK) begin
    int g;
    if (nRST === 1'b0) begin
      m_started = 1;
      m_ptr = 0; m_rv = 0; m_id = 0; m_flags_res = '0;
    end else if (m_started) begin
      g = model_grant();
      if (g >= 0) begin
        m_flags_res = alu_fn(req_aluop[g*AW +: AW], req_port_a[g*WW +: WW], req_port_b[g*WW +: WW]);
        m_id  = g;
        m_rv  = 1;
        m_ptr = (g + 1) % NREQ;
      end else if (resp_ready) begin
        m_rv = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    int g;
    logic [NREQ-1:0] exp_rdy;
    if (m_started) begin
      g = model_grant();
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("cmp_req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("cmp_alu_enable", 64'(alu_enable), 64'(g >= 0));
      chk("cmp_alu_aluop", 64'(alu_aluop), (g >= 0) ? 64'(req_aluop[g*AW +: AW]) : 64'd0);
      chk("cmp_alu_port_a", 64'(alu_port_a), (g >= 0) ? 64'(req_port_a[g*WW +: WW]) : 64'd0);
      chk("cmp_alu_port_b", 64'(alu_port_b), (g >= 0) ? 64'(req_port_b[g*WW +: WW]) : 64'd0);
      chk("cmp_resp_valid", 64'(resp_valid), 64'(m_rv));
      chk("cmp_resp_id", 64'(resp_id), 64'(m_id));
      chk("cmp_resp_data", 64'({resp_negative, resp_overflow, resp_zero, resp_result}), 64'(m_flags_res));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_valid[i]          = v;
    req_aluop[i*AW +: AW] = op;
    req_port_a[i*WW +: WW] = a;
    req_port_b[i*WW +: WW] = b;
  endtask

  initial begin
    nRST = 1'b0; resp_ready = 1'b1;
    req_valid = '0; req_aluop = '0; req_port_a = '0; req_port_b = '0;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, OP_ADD, 32'(100 + i), 32'(i));

    // Reset held two edges with every requester asserting.
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_req_ready", 64'(req_ready), 64'd0);
      chk("rst_alu_enable", 64'(alu_enable), 64'd0);
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    end

    // Round-robin from requester 0: 0,1,2,3,0.
    nRST = 1'b1; #1;
    chk("first_grant", 64'(req_ready), 64'b0001);
    tick();
    chk("rr_id0", 64'(resp_id), 64'd0);
    chk("rr_res0", 64'(resp_result), 64'd100);
    for (int n = 1; n <= 4; n++) begin
      tick();
      chk("rr_valid", 64'(resp_valid), 64'd1);
      chk("rr_id", 64'(resp_id), 64'(n % 4));
    end
    req_valid = '0;
    tick();
    chk("drain_valid", 64'(resp_valid), 64'd0);

    // Single request from requester 2: ADD 5+7.
    set_req(2, 1'b1, OP_ADD, 32'd5, 32'd7); #1;
    chk("single_ready", 64'(req_ready), 64'b0100);
    chk("single_enable", 64'(alu_enable), 64'd1);
    tick();
    req_valid = '0;
    chk("single_valid", 64'(resp_valid), 64'd1);
    chk("single_id", 64'(resp_id), 64'd2);
    chk("single_res", 64'(resp_result), 64'd12);
    chk("single_zero", 64'(resp_zero), 64'd0);

    // Backpressure: requester 1 SUB 3-3 then stall while requester 3 waits.
    set_req(1, 1'b1, OP_SUB, 32'd3, 32'd3);
    tick();
    set_req(1, 1'b0, OP_SUB, 32'd3, 32'd3);
    set_req(3, 1'b1, OP_ADD, 32'd9, 32'd1);
    resp_ready = 1'b0; #1;
    chk("bp_id", 64'(resp_id), 64'd1);
    for (int c = 0; c < 2; c++) begin
      chk("bp_ready_blocked", 64'(req_ready), 64'd0);
      tick();
      chk("bp_res_hold", 64'(resp_result), 64'd0);
      chk("bp_zero_hold", 64'(resp_zero), 64'd1);
    end
    resp_ready = 1'b1; #1;
    chk("bp_release_grant", 64'(req_ready), 64'b1000);
    tick();
    req_valid = '0;
    chk("bp_id3", 64'(resp_id), 64'd3);
    chk("bp_res3", 64'(resp_result), 64'd10);
    tick();

    // Overflow: 0x7FFFFFFF + 1 from requester 0.
    set_req(0, 1'b1, OP_ADD, 32'h7FFF_FFFF, 32'd1);
    tick();
    req_valid = '0;
    chk("ovf_res", 64'(resp_result), 64'h8000_0000);
    chk("ovf_neg", 64'(resp_negative), 64'd1);
    chk("ovf_ovf", 64'(resp_overflow), 64'd1);
    chk("ovf_zero", 64'(resp_zero), 64'd0);

    // Mid-operation reset: capture from requester 2, stall, then reset.
    set_req(2, 1'b1, OP_AND, 32'hF0F0_00FF, 32'h0FF0_0F0F);
    tick();
    req_valid = '0;
    chk("mid_id", 64'(resp_id), 64'd2);
    chk("mid_res", 64'(resp_result), 64'h00F0_000F);
    resp_ready = 1'b0;
    tick();
    nRST = 1'b0;
    set_req(1, 1'b1, OP_ADD, 32'd1, 32'd1);
    set_req(3, 1'b1, OP_ADD, 32'd2, 32'd2); #1;
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    tick();
    chk("mid_rst_valid", 64'(resp_valid), 64'd0);
    chk("mid_rst_id", 64'(resp_id), 64'd0);
    nRST = 1'b1; resp_ready = 1'b1; #1;
    chk("mid_ptr_reset", 64'(req_ready), 64'b0010);
    tick();
    req_valid = '0;
    chk("mid_post_id", 64'(resp_id), 64'd1);
    chk("mid_post_res", 64'(resp_result), 64'd2);
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
